// File: rtl/hack_data_memory_pkg.sv
// hack_data_memory_pkg: Hack data-bus memory map, status bit indices and region decode helper.
package hack_data_memory_pkg;
    localparam logic [14:0] RAM_BASE            = 15'h0000;
    localparam logic [14:0] SCREEN_BASE         = 15'h4000;
    localparam int          SCREEN_WORDS        = 8192;
    localparam int          SCR_AW              = 13;
    localparam logic [14:0] KBD_ADDR_DEFAULT    = 15'h6000;
    localparam logic [14:0] STATUS_ADDR_DEFAULT = 15'h6001;
    localparam int          ST_FIFO_EMPTY       = 0;
    localparam int          ST_FIFO_FULL        = 1;
    localparam int          ST_OVERFLOW         = 2;
    localparam int          ST_KBD_FULL         = 3;
    localparam int          SCR_FIFO_W          = SCR_AW + 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_STATUS
    } region_e;

    // RAM wins over nothing else: with RAM_AW <= 14 it never reaches the screen window.
    function automatic region_e decode_region(input logic [14:0] addr, input int ram_words,
                                              input logic [14:0] kbd_a, input logic [14:0] stat_a);
        return (int'(addr) < ram_words)          ? REG_RAM    :
               (addr[14:13] == SCREEN_BASE[14:13]) ? REG_SCREEN :
               (addr == kbd_a)                   ? REG_KBD    :
               (addr == stat_a)                  ? REG_STATUS : REG_NONE;
    endfunction
endpackage

// File: rtl/hack_sync_fifo.sv
// hack_sync_fifo: synchronous FIFO with async reset; accepts a push while full if a pop coincides.
//  clk, reset       clock, asynchronous active-high reset (discards contents)
//  push, din        write request and data (dropped when full without pop)
//  pop, dout        read request and head data (head is combinational)
//  full, empty      occupancy flags
module hack_sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = cnt_q == (AW+1)'(DEPTH);
        empty    = cnt_q == '0;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        dout     = mem[rd_ptr_q];
    end

    // When full, wr_ptr equals rd_ptr; the head is read before the edge overwrites that slot.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack CPU data-bus responder - RAM, screen shadow + stream, keyboard latch, status.
//  clk, reset                   clock, asynchronous active-high reset
//  address_m, out_m, write_m    CPU data bus (write commits at next rising edge)
//  in_m                         combinational read data
//  scr_valid/ready/addr/data    screen write stream out of the FIFO
//  kbd_valid/code/ready         keyboard code stream into the latch
module hack_data_memory
    import hack_data_memory_pkg::*;
#(
    parameter int          RAM_AW      = 14,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [14:0] KBD_ADDR    = KBD_ADDR_DEFAULT,
    parameter logic [14:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] address_m,
    input  logic [15:0] out_m,
    input  logic        write_m,
    output logic [15:0] in_m,
    output logic        scr_valid,
    input  logic        scr_ready,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready
);
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] shadow [SCREEN_WORDS];
    region_e     region;
    logic [12:0] scr_off;
    logic        wr_ram, wr_scr, wr_kbd, wr_stat;
    logic        fifo_full, fifo_empty, scr_pop, ovf_set;
    logic [15:0] status_word;
    logic        kbd_full_q, kbd_full_d, ovf_q, ovf_d;
    logic [15:0] kbd_code_q, kbd_code_d;

    always_comb begin
        region      = decode_region(address_m, RAM_WORDS, KBD_ADDR, STATUS_ADDR);
        scr_off     = address_m[SCR_AW-1:0];
        wr_ram      = write_m && region == REG_RAM;
        wr_scr      = write_m && region == REG_SCREEN;
        wr_kbd      = write_m && region == REG_KBD;
        wr_stat     = write_m && region == REG_STATUS;
        scr_valid   = !fifo_empty;
        scr_pop     = scr_valid && scr_ready;
        kbd_ready   = !kbd_full_q;
        // A push is only dropped when full with no pop freeing a slot.
        ovf_set     = wr_scr && fifo_full && !scr_pop;
        ovf_d       = ovf_set ? 1'b1 : (wr_stat && out_m[ST_OVERFLOW]) ? 1'b0 : ovf_q;
        // CPU clear beats a simultaneous handshake.
        kbd_full_d  = wr_kbd ? 1'b0  : (kbd_valid && kbd_ready) ? 1'b1     : kbd_full_q;
        kbd_code_d  = wr_kbd ? 16'h0 : (kbd_valid && kbd_ready) ? kbd_code : kbd_code_q;
        status_word = 16'h0;
        status_word[ST_FIFO_EMPTY] = fifo_empty;
        status_word[ST_FIFO_FULL]  = fifo_full;
        status_word[ST_OVERFLOW]   = ovf_q;
        status_word[ST_KBD_FULL]   = kbd_full_q;
        in_m = (region == REG_RAM)    ? ram[address_m[RAM_AW-1:0]] :
               (region == REG_SCREEN) ? shadow[scr_off]            :
               (region == REG_KBD)    ? kbd_code_q                 :
               (region == REG_STATUS) ? status_word                : 16'h0;
    end

    always_ff @(posedge clk) begin
        if (wr_ram) ram[address_m[RAM_AW-1:0]] <= out_m;
        if (wr_scr) shadow[scr_off] <= out_m;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_full_q <= 1'b0;
            kbd_code_q <= 16'h0;
            ovf_q      <= 1'b0;
        end else begin
            kbd_full_q <= kbd_full_d;
            kbd_code_q <= kbd_code_d;
            ovf_q      <= ovf_d;
        end
    end

    hack_sync_fifo #(.WIDTH(SCR_FIFO_W), .DEPTH(FIFO_DEPTH)) u_scr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_scr),
        .din   ({scr_off, out_m}),
        .pop   (scr_pop),
        .dout  ({scr_addr, scr_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule
